// File: rtl/apb_manager_multi.sv
// APB manager: valid/ready request port onto an APB bus with NUM_SUB subordinates.
// Fixed-stride address decode, one-hot PSEL, PREADY timeout and a registered response.
module apb_manager_multi #(
    parameter int                NUM_SUB     = 4,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h1000_0000),
    parameter int                REGION_BITS = 12,
    parameter int                TIMEOUT     = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [NUM_SUB-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    input  logic [NUM_SUB*DATA_W-1:0] PRDATA,
    input  logic [NUM_SUB-1:0]        PREADY,
    input  logic [NUM_SUB-1:0]        PSLVERR,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err
);

    localparam int SW = DATA_W / 8;
    localparam int IW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TW = ADDR_W - REGION_BITS - IW;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     strb_q, strb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [IW-1:0]      idx;
    logic               tag_hit;
    logic               idx_ok;
    logic               hit;
    logic [NUM_SUB-1:0] psel_hot;
    logic               sel_rdy;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    assign idx     = addr_q[REGION_BITS +: IW];
    assign tag_hit = addr_q[ADDR_W-1 -: TW] == BASE_ADDR[ADDR_W-1 -: TW];
    assign hit     = tag_hit && idx_ok;

    // Index match doubles as the range check and the response mux select.
    always_comb begin
        idx_ok    = 1'b0;
        psel_hot  = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SUB; i++) begin
            if (idx == IW'(i)) begin
                idx_ok      = 1'b1;
                psel_hot[i] = 1'b1;
                sel_rdy     = PREADY[i];
                sel_err     = PSLVERR[i];
                sel_rdata   = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = SETUP;
            SETUP:   state_d = hit ? ACCESS : IDLE;
            ACCESS:  if (sel_rdy || cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    strb_d  = req_write ? req_strb : '0;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                if (!hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ACCESS: begin
                if (sel_rdy) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        unique case (state_q)
            IDLE:   req_ready = 1'b1;
            SETUP:  PSEL = hit ? psel_hot : '0;
            ACCESS: begin
                PSEL    = psel_hot;
                PENABLE = 1'b1;
            end
            default: ;
        endcase
    end

    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign PSTRB     = strb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_manager_multi.sv
// Directed bench for apb_manager_multi: vector table plus back-to-back,
// timeout and mid-transfer reset sequences.
module tb_apb_manager_multi;

    localparam int NS = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0] PREADY;
    logic [NS-1:0] PSLVERR;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_strb;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    apb_manager_multi dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          sub;
        int          waits;
        logic        serr;
        logic [31:0] prd;
        logic [3:0]  e_psel;
        int          e_pen;
        int          e_lat;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(
        input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] strb, input int sub, input int waits,
        input logic serr, input logic [31:0] prd, input logic [3:0] e_psel,
        input int e_pen, input int e_lat, input logic e_err,
        input logic [31:0] e_rdata, input logic [3:0] e_strb);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.sub = sub; v.waits = waits; v.serr = serr; v.prd = prd;
        v.e_psel = e_psel; v.e_pen = e_pen; v.e_lat = e_lat;
        v.e_err = e_err; v.e_rdata = e_rdata; v.e_strb = e_strb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] oh;
        logic [3:0] seen;
        int lat, pen, pcyc, bad;
        logic got;
        oh = 4'b0001 << v.sub;
        // Unselected subordinates look ready and erroring: must be ignored.
        PREADY  = ~oh;
        PSLVERR = ~oh | (v.serr ? oh : 4'b0000);
        for (int i = 0; i < NS; i++)
            PRDATA[i*32 +: 32] = (i == v.sub) ? v.prd : (32'hBAD0_0000 | 32'(i));
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        chk($sformatf("v%0d req_ready", id), 32'(req_ready), 32'd1);
        @(posedge PCLK);
        lat = 0; pen = 0; pcyc = 0; bad = 0; got = 1'b0; seen = 4'b0000;
        while (!got && lat < 40) begin
            @(negedge PCLK);
            lat++;
            req_valid = 1'b0;
            if (lat == 1)
                chk($sformatf("v%0d pstrb", id), 32'(PSTRB), 32'(v.e_strb));
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                if (PSEL != 0) begin
                    pcyc++;
                    seen |= PSEL;
                    if (PADDR !== v.addr || PWRITE !== v.wr ||
                        PWDATA !== v.wdata || PSTRB !== v.e_strb)
                        bad++;
                end
                if (PENABLE) begin
                    pen++;
                    if (pen > v.waits) PREADY = 4'hF;
                end
            end
        end
        chk($sformatf("v%0d rsp_seen", id), 32'(got), 32'd1);
        chk($sformatf("v%0d latency", id), 32'(lat), 32'(v.e_lat));
        chk($sformatf("v%0d penable_cycles", id), 32'(pen), 32'(v.e_pen));
        chk($sformatf("v%0d psel_cycles", id), 32'(pcyc),
            (v.e_psel != 0) ? 32'(v.e_pen + 1) : 32'd0);
        chk($sformatf("v%0d psel", id), 32'(seen), 32'(v.e_psel));
        chk($sformatf("v%0d bus_stable", id), 32'(bad), 32'd0);
        chk($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'(v.e_err));
        chk($sformatf("v%0d rsp_rdata", id), rsp_rdata, v.e_rdata);
        @(negedge PCLK);
        chk($sformatf("v%0d rsp_pulse", id), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d err_hold", id), 32'(rsp_err), 32'(v.e_err));
        chk($sformatf("v%0d rdata_hold", id), rsp_rdata, v.e_rdata);
        PREADY  = '0;
        PSLVERR = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rise1, rise2, cyc, nrsp, k;
        logic prev, saw;

        tbl[0]  = mk(1, 32'h1000_1004, 32'hA5A5_5A5A, 4'hF, 1, 0, 0, 32'h0,
                     4'b0010, 1, 3, 0, 32'h0, 4'hF);
        tbl[1]  = mk(0, 32'h1000_3000, 32'h0, 4'hF, 3, 3, 0, 32'hDEAD_BEEF,
                     4'b1000, 4, 6, 0, 32'hDEAD_BEEF, 4'h0);
        tbl[2]  = mk(0, 32'h2000_0000, 32'h0, 4'hF, 0, 0, 0, 32'h1111_1111,
                     4'b0000, 0, 2, 1, 32'h0, 4'h0);
        tbl[3]  = mk(1, 32'h1000_2008, 32'h1122_3344, 4'hF, 2, 255, 0, 32'h0,
                     4'b0100, 16, 18, 1, 32'h0, 4'hF);
        tbl[4]  = mk(0, 32'h1000_0010, 32'h0, 4'hF, 0, 0, 1, 32'hCAFE_F00D,
                     4'b0001, 1, 3, 1, 32'h0, 4'h0);
        tbl[5]  = mk(0, 32'h1000_2FFC, 32'h0, 4'h0, 2, 1, 0, 32'h1234_5678,
                     4'b0100, 2, 4, 0, 32'h1234_5678, 4'h0);
        tbl[6]  = mk(1, 32'h1000_3FF0, 32'h0BAD_C0DE, 4'h6, 3, 2, 1, 32'h0,
                     4'b1000, 3, 5, 1, 32'h0, 4'h6);
        tbl[7]  = mk(0, 32'h0FFF_FFFC, 32'h0, 4'h0, 0, 0, 0, 32'h5555_5555,
                     4'b0000, 0, 2, 1, 32'h0, 4'h0);
        tbl[8]  = mk(1, 32'h1000_4000, 32'h7777_8888, 4'h3, 0, 0, 0, 32'h0,
                     4'b0000, 0, 2, 1, 32'h0, 4'h3);
        tbl[9]  = mk(1, 32'h1000_0000, 32'h0000_00FF, 4'h3, 0, 0, 0, 32'h0,
                     4'b0001, 1, 3, 0, 32'h0, 4'h3);
        tbl[10] = mk(0, 32'h1000_1000, 32'h0, 4'h0, 1, 0, 0, 32'h8000_0001,
                     4'b0010, 1, 3, 0, 32'h8000_0001, 4'h0);

        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset psel", 32'(PSEL), 32'd0);
        chk("reset penable", 32'(PENABLE), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset paddr", PADDR, 32'd0);
        chk("reset pwdata", PWDATA, 32'd0);
        chk("reset pstrb", 32'(PSTRB), 32'd0);
        chk("reset pwrite", 32'(PWRITE), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("idle req_ready", 32'(req_ready), 32'd1);
        chk("idle rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        // Back-to-back: req_valid held across two requests.
        PREADY = 4'b0010; PSLVERR = '0; PRDATA = '0;
        req_write = 1'b1; req_addr = 32'h1000_1004;
        req_wdata = 32'h0102_0304; req_strb = 4'hF;
        req_valid = 1'b1;
        rise1 = -1; rise2 = -1; cyc = 0; nrsp = 0; prev = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge PCLK);
            cyc++;
            if (PSEL != 0 && !prev) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) begin
                    rise2 = cyc;
                    req_valid = 1'b0;
                end
            end
            prev = (PSEL != 0);
            if (rsp_valid) begin
                nrsp++;
                chk("b2b req_ready_at_rsp", 32'(req_ready), 32'd1);
            end
        end
        req_valid = 1'b0;
        chk("b2b psel_spacing", 32'(rise2 - rise1), 32'd3);
        chk("b2b rsp_count", 32'(nrsp), 32'd2);
        PREADY = '0;

        // Reset asserted mid-ACCESS.
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_2008;
        req_wdata = 32'hFEED_0001; req_strb = 4'hF;
        @(posedge PCLK);
        @(negedge PCLK);
        req_valid = 1'b0;
        k = 0;
        while (!PENABLE && k < 5) begin
            @(negedge PCLK);
            k++;
        end
        chk("rst reach_access", 32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("rst psel", 32'(PSEL), 32'd0);
        chk("rst penable", 32'(PENABLE), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst paddr", PADDR, 32'd0);
        chk("rst pwdata", PWDATA, 32'd0);
        chk("rst pstrb", 32'(PSTRB), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL != 0) saw = 1'b1;
        end
        chk("rst no_response", 32'(saw), 32'd0);
        run_vec(tbl[0], 100);
        run_vec(tbl[1], 101);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
